// File: rtl/dmux4way_dispatcher_pkg.sv
// Shared encodings for the 4-way dispatcher: FSM state codes, channel indices
// and the channel rotation helper.
package dmux4way_dispatcher_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] ch_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t HOLD     = 2'd1;
  localparam state_t RETARGET = 2'd2;

  localparam ch_t CH_A = 2'd0;
  localparam ch_t CH_B = 2'd1;
  localparam ch_t CH_C = 2'd2;
  localparam ch_t CH_D = 2'd3;

  // Channel after ch, wrapping d -> a.
  function automatic ch_t next_ch(input ch_t ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/dmux4way_dispatcher_if.sv
// Source/consumer bus of the 4-way dispatcher: input handshake, shared data,
// one-hot channel valids/readys and the counter read port.
interface dmux4way_dispatcher_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);

  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             a_valid;
  logic             b_valid;
  logic             c_valid;
  logic             d_valid;
  logic             a_ready;
  logic             b_ready;
  logic             c_ready;
  logic             d_ready;
  logic [1:0]       count_sel;
  logic [CNT_W-1:0] count;

  modport master (
    output in, in_valid, mode, sel, a_ready, b_ready, c_ready, d_ready, count_sel,
    input  in_ready, out, a_valid, b_valid, c_valid, d_valid, count
  );

  modport slave (
    input  in, in_valid, mode, sel, a_ready, b_ready, c_ready, d_ready, count_sel,
    output in_ready, out, a_valid, b_valid, c_valid, d_valid, count
  );

endinterface

// File: rtl/dmux4way_dispatcher_dmux.sv
// 4-way demultiplexer gate: routes a single bit to one of four outputs.
module dmux4way_dispatcher_dmux (
  input  logic       in_i,
  input  logic [1:0] sel_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       d_o
);

  always_comb begin
    a_o = 1'b0;
    b_o = 1'b0;
    c_o = 1'b0;
    d_o = 1'b0;
    unique case (sel_i)
      2'd0: a_o = in_i;
      2'd1: b_o = in_i;
      2'd2: c_o = in_i;
      2'd3: d_o = in_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmux4way_dispatcher.sv
// Dispatches captured words to one of four consumers, directed or round-robin,
// with a one-word holding register, stall re-targeting and per-channel counters.
module dmux4way_dispatcher
  import dmux4way_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 7
) (
  input logic                 clock,
  input logic                 reset,
  dmux4way_dispatcher_if.slave bus
);

  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  ch_t               target_q, target_d;
  ch_t               rr_ptr_q, rr_ptr_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];

  logic [3:0] ready_vec;
  logic       tgt_ready;
  logic       held_valid;
  logic       in_ready;

  assign ready_vec  = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
  assign tgt_ready  = ready_vec[target_q];
  assign held_valid = (state_q == HOLD);
  assign in_ready   = (state_q == IDLE) && !reset;

  assign bus.in_ready = in_ready;
  assign bus.out      = out_q;
  assign bus.count    = cnt_q[bus.count_sel];

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    target_d = target_q;
    rr_ptr_d = rr_ptr_q;
    stall_d  = stall_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          out_d    = bus.in;
          stall_d  = '0;
          mode_d   = bus.mode;
          target_d = bus.mode ? rr_ptr_q : bus.sel;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (tgt_ready) begin
          cnt_d[target_q] = cnt_q[target_q] + 1'b1;
          if (mode_q) rr_ptr_d = next_ch(target_q);
          state_d = IDLE;
        end else if (mode_q && (stall_q == StallW'(TIMEOUT))) begin
          state_d = RETARGET;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      RETARGET: begin
        // Word stays held; only the destination moves on.
        target_d = next_ch(target_q);
        stall_d  = '0;
        state_d  = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      target_q <= CH_A;
      rr_ptr_q <= CH_A;
      stall_q  <= '0;
      mode_q   <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      target_q <= target_d;
      rr_ptr_q <= rr_ptr_d;
      stall_q  <= stall_d;
      mode_q   <= mode_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  dmux4way_dispatcher_dmux u_dmux (
    .in_i  (held_valid),
    .sel_i (target_q),
    .a_o   (bus.a_valid),
    .b_o   (bus.b_valid),
    .c_o   (bus.c_valid),
    .d_o   (bus.d_valid)
  );

endmodule

// File: tb/tb_dmux4way_dispatcher.sv
// Directed bench for dmux4way_dispatcher: a vector table of single-word
// transactions plus hand-written timeout, stall, reset and wrap sequences.
module tb_dmux4way_dispatcher;

  logic clock;
  logic reset;

  int n_cmp;
  int n_bad;
  int exp_cnt [4];

  dmux4way_dispatcher_if #(.WIDTH(16), .CNT_W(8)) bus ();

  dmux4way_dispatcher #(
    .WIDTH   (16),
    .CNT_W   (8),
    .TIMEOUT (7)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  rdy;
    int unsigned exp_ch;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] valids();
    return {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
  endfunction

  task automatic set_ready(input logic [3:0] r);
    {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready} = r;
  endtask

  task automatic chk_counts(input string name);
    for (int i = 0; i < 4; i++) begin
      bus.count_sel = 2'(i);
      #1;
      chk(name, 32'(bus.count), 32'(exp_cnt[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
  endtask

  // Present a word for one cycle; returns with the DUT in its first HOLD cycle.
  task automatic capture(input logic m, input logic [1:0] s, input logic [15:0] d);
    bus.in       = d;
    bus.mode     = m;
    bus.sel      = s;
    bus.in_valid = 1'b1;
    chk("in_ready_before_capture", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.mode     = ~m;
    bus.sel      = ~s;
    bus.in       = 16'hDEAD;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    bus.count_sel = 2'd0;
    set_ready(4'b0000);

    vecs[0] = '{1'b0, 2'd2, 16'h00A5, 4'b0100, 2};
    vecs[1] = '{1'b1, 2'd3, 16'h0001, 4'b1111, 0};
    vecs[2] = '{1'b1, 2'd0, 16'h0002, 4'b1111, 1};
    vecs[3] = '{1'b1, 2'd1, 16'h0003, 4'b1111, 2};
    vecs[4] = '{1'b1, 2'd2, 16'h0004, 4'b1111, 3};
    vecs[5] = '{1'b1, 2'd2, 16'h0005, 4'b1111, 0};
    vecs[6] = '{1'b0, 2'd1, 16'h1234, 4'b1111, 1};
    vecs[7] = '{1'b1, 2'd0, 16'h5678, 4'b1111, 1};
    vecs[8] = '{1'b0, 2'd3, 16'hFFFF, 4'b1000, 3};
    vecs[9] = '{1'b1, 2'd0, 16'h8001, 4'b0100, 2};

    // Reset state
    do_reset();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_valids", 32'(valids()), 32'd0);
    chk("reset_out", 32'(bus.out), 32'd0);
    chk_counts("reset_count");
    reset = 1'b0;
    step();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Table: one word per record, readys held for the whole transaction
    for (int i = 0; i < 10; i++) begin
      set_ready(vecs[i].rdy);
      capture(vecs[i].mode, vecs[i].sel, vecs[i].data);
      chk($sformatf("v%0d_valids", i), 32'(valids()), 32'(4'b0001 << vecs[i].exp_ch));
      chk($sformatf("v%0d_out", i), 32'(bus.out), 32'(vecs[i].data));
      chk($sformatf("v%0d_busy", i), 32'(bus.in_ready), 32'd0);
      step();
      exp_cnt[vecs[i].exp_ch]++;
      chk($sformatf("v%0d_done_valids", i), 32'(valids()), 32'd0);
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      bus.count_sel = 2'(vecs[i].exp_ch);
      #1;
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(exp_cnt[vecs[i].exp_ch]));
    end
    chk_counts("table_counts");

    // Round-robin timeout: a never ready, re-target to b
    do_reset();
    reset = 1'b0;
    step();
    set_ready(4'b0010);
    capture(1'b1, 2'd0, 16'hBEEF);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to_hold_a_%0d", k), 32'(valids()), 32'b0001);
      step();
    end
    chk("to_retarget_valids", 32'(valids()), 32'd0);
    chk("to_retarget_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("to_hold_b", 32'(valids()), 32'b0010);
    chk("to_word_kept", 32'(bus.out), 32'hBEEF);
    step();
    exp_cnt[1]++;
    chk("to_delivered", 32'(valids()), 32'd0);
    chk_counts("to_counts");

    // Directed mode waits indefinitely
    set_ready(4'b0000);
    capture(1'b0, 2'd3, 16'h0D0D);
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("dir_hold_%0d", k), 32'(valids()), 32'b1000);
      step();
    end
    set_ready(4'b1000);
    chk("dir_still_held", 32'(valids()), 32'b1000);
    step();
    exp_cnt[3]++;
    chk("dir_delivered", 32'(valids()), 32'd0);
    chk("dir_in_ready", 32'(bus.in_ready), 32'd1);
    chk_counts("dir_counts");

    // Reset while holding a word for b
    set_ready(4'b0000);
    capture(1'b0, 2'd1, 16'h0B0B);
    chk("mid_hold_b", 32'(valids()), 32'b0010);
    reset = 1'b1;
    #1;
    chk("mid_reset_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    chk("mid_reset_valids", 32'(valids()), 32'd0);
    chk_counts("mid_reset_counts");
    reset = 1'b0;
    step();
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_reset_valids", 32'(valids()), 32'd0);

    // Counter wrap on channel a
    set_ready(4'b0001);
    bus.count_sel = 2'd0;
    for (int k = 0; k < 256; k++) begin
      bus.in       = 16'(k);
      bus.mode     = 1'b0;
      bus.sel      = 2'd0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      if (k == 254) begin
        bus.count_sel = 2'd0;
        #1;
        chk("wrap_255", 32'(bus.count), 32'd255);
      end
    end
    bus.count_sel = 2'd0;
    #1;
    chk("wrap_0", 32'(bus.count), 32'd0);
    chk("wrap_last_out", 32'(bus.out), 32'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
